// File: rtl/lbp_host_pkg.sv
// Shared constants, state encoding and address helpers for the LBP host memory.
package lbp_host_pkg;

    localparam int IMG_W      = 128;
    localparam int ADDR_W     = 14;
    localparam int NPIX       = IMG_W * IMG_W;
    localparam int LBP_WRITES = (IMG_W - 2) * (IMG_W - 2);
    localparam int PIX_W      = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SERVE = 3'd2,
        DUMP  = 3'd3,
        DONE  = 3'd4
    } lbp_state_e;

    // True when a raster address sits on the outer ring of an img_w x img_w image.
    function automatic logic is_border(input int unsigned addr, input int unsigned img_w);
        int unsigned row;
        int unsigned col;
        row = addr / img_w;
        col = addr % img_w;
        return (row == 0) || (row == img_w - 1) || (col == 0) || (col == img_w - 1);
    endfunction

endpackage

// File: rtl/lbp_host_mem_if.sv
// Bus between the LBP host memory (slave) and the host/engine side (master).
interface lbp_host_mem_if #(
    parameter int ADDR_W = lbp_host_pkg::ADDR_W
);
    import lbp_host_pkg::*;

    // load_* and dump_* are valid/ready streams: a beat moves on a rising edge where
    // both are high, and the producer holds data steady while valid waits for ready.
    logic              load_valid;
    logic [PIX_W-1:0]  load_data;
    logic              load_ready;
    logic              gray_req;
    logic [ADDR_W-1:0] gray_addr;
    logic              gray_ready;
    logic [PIX_W-1:0]  gray_data;
    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic [PIX_W-1:0]  lbp_data;
    logic              finish;
    logic              dump_valid;
    logic [PIX_W-1:0]  dump_data;
    logic              dump_ready;
    logic              done;
    logic [ADDR_W:0]   wr_count;

    modport slave (
        input  load_valid, load_data, gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data,
               finish, dump_ready,
        output load_ready, gray_ready, gray_data, dump_valid, dump_data, done, wr_count
    );

    modport master (
        output load_valid, load_data, gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data,
               finish, dump_ready,
        input  load_ready, gray_ready, gray_data, dump_valid, dump_data, done, wr_count
    );

endinterface

// File: rtl/lbp_host_ram.sv
// Simple RAM: one synchronous write port, one asynchronous read port, no reset on contents.
module lbp_host_ram #(
    parameter int AW = 14,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [1 << AW];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lbp_host_mem.sv
// Host memory for an LBP engine: load gray image, serve reads and result writes, stream results out.
// Defining LBP_HOST_ERRCHK_EN adds the sticky err[2:0] output and a per-address written-bit array.
module lbp_host_mem #(
    parameter int IMG_W  = lbp_host_pkg::IMG_W,
    parameter int ADDR_W = lbp_host_pkg::ADDR_W
) (
    input  logic          clk,
    input  logic          reset,
    lbp_host_mem_if.slave bus,
    output logic [2:0]    state_o
`ifdef LBP_HOST_ERRCHK_EN
    ,
    output logic [2:0]    err
`endif
);
    import lbp_host_pkg::*;

    localparam int                NPIX_L = IMG_W * IMG_W;
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(NPIX_L - 1);
    localparam logic [ADDR_W:0]   WR_MAX = (ADDR_W + 1)'(NPIX_L);

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_LOAD  = LOAD;
    localparam logic [2:0] S_SERVE = SERVE;
    localparam logic [2:0] S_DUMP  = DUMP;
    localparam logic [2:0] S_DONE  = DONE;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] load_cnt_q, load_cnt_d;
    logic [ADDR_W-1:0] dump_cnt_q, dump_cnt_d;
    logic [ADDR_W:0]   wr_count_q, wr_count_d;
    logic              gray_ready_q, gray_ready_d;

    logic              load_fire, lbp_fire, finish_fire, dump_fire;
    logic              lbp_we;
    logic [ADDR_W-1:0] lbp_waddr;
    logic [PIX_W-1:0]  lbp_wdata;
    logic [PIX_W-1:0]  gray_rdata, lbp_rdata;

    assign load_fire   = (state_q == S_LOAD)  && bus.load_valid;
    assign lbp_fire    = (state_q == S_SERVE) && bus.lbp_valid;
    assign finish_fire = (state_q == S_SERVE) && bus.finish;
    assign dump_fire   = (state_q == S_DUMP)  && bus.dump_ready;

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        dump_cnt_d = dump_cnt_q;
        wr_count_d = wr_count_q;
        case (state_q)
            S_IDLE: begin
                // Every pass through IDLE re-arms the counters for a fresh image.
                state_d    = S_LOAD;
                load_cnt_d = '0;
                dump_cnt_d = '0;
                wr_count_d = '0;
            end
            S_LOAD: begin
                if (load_fire) begin
                    load_cnt_d = load_cnt_q + ADDR_W'(1);
                    if (load_cnt_q == LAST) begin
                        state_d = S_SERVE;
                    end
                end
            end
            S_SERVE: begin
                if (lbp_fire && (wr_count_q != WR_MAX)) begin
                    wr_count_d = wr_count_q + (ADDR_W + 1)'(1);
                end
                if (finish_fire) begin
                    state_d = S_DUMP;
                end
            end
            S_DUMP: begin
                if (dump_fire) begin
                    dump_cnt_d = dump_cnt_q + ADDR_W'(1);
                    if (dump_cnt_q == LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign gray_ready_d = (state_d == S_SERVE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            load_cnt_q   <= '0;
            dump_cnt_q   <= '0;
            wr_count_q   <= '0;
            gray_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            dump_cnt_q   <= dump_cnt_d;
            wr_count_q   <= wr_count_d;
            gray_ready_q <= gray_ready_d;
        end
    end

    // Loading clears the result image so unwritten border entries read back as zero.
    assign lbp_we    = load_fire || lbp_fire;
    assign lbp_waddr = load_fire ? load_cnt_q : bus.lbp_addr;
    assign lbp_wdata = load_fire ? '0 : bus.lbp_data;

    lbp_host_ram #(.AW(ADDR_W), .DW(PIX_W)) gray_mem (
        .clk     (clk),
        .we_i    (load_fire),
        .waddr_i (load_cnt_q),
        .wdata_i (bus.load_data),
        .raddr_i (bus.gray_addr),
        .rdata_o (gray_rdata)
    );

    lbp_host_ram #(.AW(ADDR_W), .DW(PIX_W)) lbp_mem (
        .clk     (clk),
        .we_i    (lbp_we),
        .waddr_i (lbp_waddr),
        .wdata_i (lbp_wdata),
        .raddr_i (dump_cnt_q),
        .rdata_o (lbp_rdata)
    );

    assign bus.load_ready = (state_q == S_LOAD);
    assign bus.gray_ready = gray_ready_q;
    assign bus.gray_data  = ((state_q == S_SERVE) && bus.gray_req) ? gray_rdata : '0;
    assign bus.dump_valid = (state_q == S_DUMP);
    assign bus.dump_data  = (state_q == S_DUMP) ? lbp_rdata : '0;
    assign bus.done       = (state_q == S_DONE);
    assign bus.wr_count   = wr_count_q;
    assign state_o        = state_q;

`ifdef LBP_HOST_ERRCHK_EN
    localparam logic [ADDR_W:0] LBP_WR = (ADDR_W + 1)'((IMG_W - 2) * (IMG_W - 2));

    logic [NPIX_L-1:0] written_q;
    logic [2:0]        err_q;

    // Written bits are cleared address by address as the next image loads.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            written_q[load_cnt_q] <= 1'b0;
        end else if (lbp_fire) begin
            written_q[bus.lbp_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= '0;
        end else begin
            if (lbp_fire && is_border(32'(bus.lbp_addr), IMG_W)) begin
                err_q[0] <= 1'b1;
            end
            if (lbp_fire && written_q[bus.lbp_addr]) begin
                err_q[1] <= 1'b1;
            end
            if (finish_fire && (wr_count_d != LBP_WR)) begin
                err_q[2] <= 1'b1;
            end
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_lbp_host_mem.sv
// Bench for lbp_host_mem: full 128x128 run against a phase-level model, plus a 16x16 instance
// for the error-flag stimulus (err checked when LBP_HOST_ERRCHK_EN is defined).
module tb_lbp_host_mem;

    localparam int W     = 128;
    localparam int AW    = 14;
    localparam int NPIX  = W * W;
    localparam int WS    = 16;
    localparam int AWS   = 8;
    localparam int NPIXS = WS * WS;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rst_s = 1'b1;
    always #5 clk = ~clk;

    lbp_host_mem_if #(.ADDR_W(AW))  bus ();
    lbp_host_mem_if #(.ADDR_W(AWS)) bus_s ();
    logic [2:0] state, state_s;
`ifdef LBP_HOST_ERRCHK_EN
    logic [2:0] err, err_s;
`endif

    lbp_host_mem #(.IMG_W(W), .ADDR_W(AW)) dut (
        .clk     (clk),
        .reset   (rst),
        .bus     (bus),
        .state_o (state)
`ifdef LBP_HOST_ERRCHK_EN
        ,
        .err     (err)
`endif
    );

    lbp_host_mem #(.IMG_W(WS), .ADDR_W(AWS)) dut_s (
        .clk     (clk),
        .reset   (rst_s),
        .bus     (bus_s),
        .state_o (state_s)
`ifdef LBP_HOST_ERRCHK_EN
        ,
        .err     (err_s)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference LBP of the ramp image: bit k set when neighbour k >= centre.
    function automatic logic [7:0] lbp_ref(input int a);
        int dr [8] = '{-1, -1, -1, 0, 1, 1, 1, 0};
        int dc [8] = '{-1, 0, 1, 1, 1, 0, -1, -1};
        int r, c, ctr, nb;
        logic [7:0] v;
        r = a / W;
        c = a % W;
        ctr = a % 256;
        v = '0;
        for (int k = 0; k < 8; k++) begin
            nb = ((r + dr[k]) * W + c + dc[k]) % 256;
            v[k] = (nb >= ctr);
        end
        return v;
    endfunction

    // Phase-level model of the large instance, advanced on each rising edge.
    typedef enum int {P_IDLE, P_LOAD, P_SERVE, P_DUMP, P_DONE} phase_e;
    phase_e     m_ph = P_IDLE;
    int         m_n  = 0;
    int         m_wr = 0;
    logic [7:0] m_gray   [NPIX];
    logic [7:0] m_lbp    [NPIX];
    logic [7:0] gold     [NPIX];
    logic [7:0] dump_cap [NPIX];
    int         done_cnt = 0;
    bit         chk_en   = 1'b0;
    logic [7:0] exp_q [$];

    always @(posedge clk) begin
        if (rst) begin
            m_ph <= P_IDLE;
            m_n  <= 0;
            m_wr <= 0;
        end else begin
            case (m_ph)
                P_IDLE: begin
                    m_ph <= P_LOAD;
                    m_n  <= 0;
                    m_wr <= 0;
                end
                P_LOAD: if (bus.load_valid) begin
                    m_gray[m_n] <= bus.load_data;
                    m_lbp[m_n]  <= 8'd0;
                    m_n         <= m_n + 1;
                    if (m_n == NPIX - 1) m_ph <= P_SERVE;
                end
                P_SERVE: begin
                    if (bus.lbp_valid) begin
                        m_lbp[bus.lbp_addr] <= bus.lbp_data;
                        if (m_wr < NPIX) m_wr <= m_wr + 1;
                    end
                    if (bus.finish) begin
                        m_ph <= P_DUMP;
                        m_n  <= 0;
                    end
                end
                P_DUMP: if (bus.dump_ready) begin
                    m_n <= m_n + 1;
                    if (m_n == NPIX - 1) m_ph <= P_DONE;
                end
                default: m_ph <= P_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("load_ready", 32'(bus.load_ready), 32'(m_ph == P_LOAD));
            check("gray_ready", 32'(bus.gray_ready), 32'(m_ph == P_SERVE));
            check("gray_data", 32'(bus.gray_data),
                  32'(((m_ph == P_SERVE) && bus.gray_req) ? m_gray[bus.gray_addr] : 8'd0));
            check("dump_valid", 32'(bus.dump_valid), 32'(m_ph == P_DUMP));
            check("done", 32'(bus.done), 32'(m_ph == P_DONE));
            if (m_ph == P_SERVE || m_ph == P_DUMP) begin
                check("wr_count", 32'(bus.wr_count), 32'(m_wr));
            end
            if (m_ph == P_DUMP) begin
                check("dump_data", 32'(bus.dump_data), 32'(m_lbp[m_n]));
                if (bus.dump_ready) dump_cap[m_n] <= bus.dump_data;
            end
            if (bus.done) done_cnt <= done_cnt + 1;
        end
    end

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        bus.load_valid = 1'b0; bus.load_data = '0;
        bus.gray_req   = 1'b0; bus.gray_addr = '0;
        bus.lbp_valid  = 1'b0; bus.lbp_addr  = '0; bus.lbp_data = '0;
        bus.finish     = 1'b0; bus.dump_ready = 1'b0;
        bus_s.load_valid = 1'b0; bus_s.load_data = '0;
        bus_s.gray_req   = 1'b0; bus_s.gray_addr = '0;
        bus_s.lbp_valid  = 1'b0; bus_s.lbp_addr  = '0; bus_s.lbp_data = '0;
        bus_s.finish     = 1'b0; bus_s.dump_ready = 1'b0;
    endtask

    task automatic wait_load_ready(input string name);
        int t = 0;
        while (bus.load_ready !== 1'b1 && t < 8) begin
            @(posedge clk); #1;
            t++;
        end
        check(name, 32'(bus.load_ready), 32'd1);
    endtask

    // Ramp load; a stray result write and finish mid-load must both be ignored.
    task automatic load_ramp(input int n);
        for (int i = 0; i < n; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = i[7:0];
            bus.lbp_valid  = (i == 10);
            bus.lbp_addr   = '0;
            bus.lbp_data   = 8'hEE;
            bus.finish     = (i == 11);
            @(posedge clk); #1;
        end
        bus.load_valid = 1'b0;
        bus.lbp_valid  = 1'b0;
        bus.finish     = 1'b0;
    endtask

    initial begin
        bit pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        int t;
        int sa [3] = '{0, 200, 200};
        logic [7:0] sd [3] = '{8'h11, 8'h22, 8'h33};

        idle_inputs();
        for (int i = 0; i < NPIX; i++) begin
            if ((i / W == 0) || (i / W == W - 1) || (i % W == 0) || (i % W == W - 1))
                gold[i] = 8'd0;
            else
                gold[i] = lbp_ref(i);
        end
        gold[130] = 8'hA5;

        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_load_ready", 32'(bus.load_ready), 32'd0);
        check("rst_gray_ready", 32'(bus.gray_ready), 32'd0);
        check("rst_dump_valid", 32'(bus.dump_valid), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_wr_count", 32'(bus.wr_count), 32'd0);
        check("rst_gray_data", 32'(bus.gray_data), 32'd0);
        check("rst_state", 32'(state), 32'd0);

        // Reset in the middle of a load, then a clean reload from address 0.
        rst = 1'b0;
        wait_load_ready("first_load_ready");
        load_ramp(5000);
        bus.load_valid = 1'b1;
        bus.load_data  = 8'(5000 % 256);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midload_rst_load_ready", 32'(bus.load_ready), 32'd0);
        check("midload_rst_state", 32'(state), 32'd0);
        bus.load_valid = 1'b0;
        rst = 1'b0;
        wait_load_ready("reload_ready");
        load_ramp(NPIX);
        check("serve_load_ready_low", 32'(bus.load_ready), 32'd0);
        check("serve_gray_ready", 32'(bus.gray_ready), 32'd1);

        bus.gray_req = 1'b1; bus.gray_addr = 14'd129;
        #1;
        check("gray_129", 32'(bus.gray_data), 32'd129);
        bus.gray_req = 1'b0; bus.gray_addr = 14'd500;
        #1;
        check("gray_noreq", 32'(bus.gray_data), 32'd0);

        bus.lbp_valid = 1'b1; bus.lbp_addr = 14'd130; bus.lbp_data = 8'hA5;
        @(posedge clk); #1;
        bus.lbp_valid = 1'b0;
        check("wr_count_first", 32'(bus.wr_count), 32'd1);

        // Reference engine: one read and one result write per cycle; finish rides the last write.
        for (int r = 1; r < W - 1; r++) begin
            for (int c = 1; c < W - 1; c++) begin
                int a;
                a = r * W + c;
                if (a != 130) begin
                    bus.gray_req  = 1'b1;
                    bus.gray_addr = a[AW-1:0];
                    bus.lbp_valid = 1'b1;
                    bus.lbp_addr  = a[AW-1:0];
                    bus.lbp_data  = gold[a];
                    bus.finish    = (a == (W - 2) * W + (W - 2));
                    @(posedge clk); #1;
                end
            end
        end
        bus.gray_req = 1'b0; bus.lbp_valid = 1'b0; bus.finish = 1'b0;
        check("wr_count_final", 32'(bus.wr_count), 32'd15876);
        check("dump_entered", 32'(bus.dump_valid), 32'd1);

        for (int k = 0; k < 8; k++) begin
            bus.dump_ready = pat[k];
            @(posedge clk); #1;
        end
        bus.dump_ready = 1'b1;
        t = 0;
        while (done_cnt == 0 && t < NPIX + 20) begin
            @(posedge clk); #1;
            t++;
        end
        check("done_seen", 32'(done_cnt), 32'd1);
        wait_load_ready("rearm_load_ready");
        check("done_once", 32'(done_cnt), 32'd1);
`ifdef LBP_HOST_ERRCHK_EN
        check("err_clean_run", 32'(err), 32'd0);
`endif
        bus.dump_ready = 1'b0;
        rst = 1'b1;

        check("beat_0", 32'(dump_cap[0]), 32'd0);
        check("beat_127", 32'(dump_cap[127]), 32'd0);
        check("beat_16256", 32'(dump_cap[16256]), 32'd0);
        check("beat_16383", 32'(dump_cap[16383]), 32'd0);
        check("beat_130", 32'(dump_cap[130]), 32'hA5);
        for (int i = 0; i < NPIX; i++) check("dump_golden", 32'(dump_cap[i]), 32'(gold[i]));

        // Small instance: border write, double write and a short write count.
        rst_s = 1'b0;
        t = 0;
        while (bus_s.load_ready !== 1'b1 && t < 8) begin
            @(posedge clk); #1;
            t++;
        end
        check("s_load_ready", 32'(bus_s.load_ready), 32'd1);
        for (int i = 0; i < NPIXS; i++) begin
            bus_s.load_valid = 1'b1;
            bus_s.load_data  = i[7:0];
            @(posedge clk); #1;
        end
        bus_s.load_valid = 1'b0;
        check("s_gray_ready", 32'(bus_s.gray_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            bus_s.lbp_valid = 1'b1;
            bus_s.lbp_addr  = sa[k][AWS-1:0];
            bus_s.lbp_data  = sd[k];
            @(posedge clk); #1;
        end
        bus_s.lbp_valid = 1'b0;
        bus_s.finish = 1'b1;
        @(posedge clk); #1;
        bus_s.finish = 1'b0;
        check("s_wr_count", 32'(bus_s.wr_count), 32'd3);
        check("s_dump_valid", 32'(bus_s.dump_valid), 32'd1);
`ifdef LBP_HOST_ERRCHK_EN
        check("s_err", 32'(err_s), 32'd7);
`endif
        for (int i = 0; i < NPIXS; i++) exp_q.push_back((i == 0) ? 8'h11 : (i == 200) ? 8'h33 : 8'h00);
        bus_s.dump_ready = 1'b1;
        while (exp_q.size() > 0) begin
            check("s_dump_data", 32'(bus_s.dump_data), 32'(exp_q.pop_front()));
            @(posedge clk); #1;
        end
        bus_s.dump_ready = 1'b0;
        check("s_done", 32'(bus_s.done), 32'd1);
        @(posedge clk); #1;
        check("s_done_pulse", 32'(bus_s.done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
